// File: rtl/cnnip_pkg.sv
// Shared types and constants for the cnnip memory read engine.
package cnnip_pkg;

    typedef enum logic [2:0] {IDLE, REQ, STALL, DRAIN, DONE} rd_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_LSB   = 2;

endpackage

// File: rtl/cnnip_mem_if.sv
// Port-a connection to blk_mem_wrapper: request (en/we/addr/din) and read response (dout/valid).
interface cnnip_mem_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, we, addr, din, input dout, valid);
    modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/cnnip_rd_fifo.sv
// Small synchronous FIFO between the read engine and the output stream; exposes its fill count.
module cnnip_rd_fifo #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic             clk_a,
    input  logic             arstz_aq,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop & (count_q != '0);
        do_push = push & ((count_q != CNT_W'(FIFO_DEPTH)) | do_pop);
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_comb begin
        rdata = mem_q[rd_ptr_q];
        count = count_q;
        full  = (count_q == CNT_W'(FIFO_DEPTH));
        empty = (count_q == '0);
    end

endmodule

// File: rtl/cnnip_mem_rd_engine.sv
// Burst-read master: one {addr,len} command becomes single-word reads streamed out through a FIFO.
// Optional perf counters (perf_words/perf_stall) are built when CNNIP_RD_PERF_EN is defined.
module cnnip_mem_rd_engine
    import cnnip_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_a,
    input  logic                  arstz_aq,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    cnnip_mem_if.master           mem_if,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
`ifdef CNNIP_RD_PERF_EN
    output logic [31:0]           perf_words,
    output logic [31:0]           perf_stall,
`endif
    output logic                  done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  room_next;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_rdata;

    cnnip_rd_fifo #(
        .WIDTH      (DATA_WIDTH + 1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_a    (clk_a),
        .arstz_aq (arstz_aq),
        .push     (push),
        .wdata    ({(rem_q == LEN_WIDTH'(1)), mem_if.dout}),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        accept     = cmd_valid & (state_q == IDLE);
        push       = (state_q == REQ) & mem_if.valid;
        pop        = ~fifo_empty & m_ready;
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        room_next  = (count_next < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // A request is only entered with a FIFO slot already guaranteed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (room_next) begin
                        state_d = REQ;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            REQ: begin
                if (mem_if.valid) begin
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end else if (room_next) begin
                        state_d = REQ;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL:   if (room_next) state_d = REQ;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (accept) begin
            addr_d = cmd_addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
            rem_d  = cmd_len;
        end else if (push) begin
            addr_d = addr_q + ADDR_WIDTH'(WORD_BYTES);
            rem_d  = rem_q - LEN_WIDTH'(1);
        end
    end

    always_comb begin
        cmd_ready   = (state_q == IDLE);
        mem_if.en   = (state_q == REQ);
        mem_if.addr = addr_q;
        mem_if.we   = 1'b0;
        mem_if.din  = '0;
        m_valid     = ~fifo_empty;
        m_data      = fifo_rdata[DATA_WIDTH-1:0];
        m_last      = ~fifo_empty & fifo_rdata[DATA_WIDTH];
        busy        = (state_q != IDLE) | ~fifo_empty;
        done        = (state_q == DONE) | (pop & fifo_rdata[DATA_WIDTH]);
    end

    no_overflow_a: assert property (@(posedge clk_a) disable iff (!arstz_aq) push |-> !fifo_full);

`ifdef CNNIP_RD_PERF_EN
    logic [31:0] perf_words_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            perf_words_q <= '0;
            perf_stall_q <= '0;
        end else if (accept) begin
            perf_words_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push && perf_words_q != '1) begin
                perf_words_q <= perf_words_q + 32'd1;
            end
            if (!fifo_empty && !m_ready && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    always_comb begin
        perf_words = perf_words_q;
        perf_stall = perf_stall_q;
    end
`endif

endmodule
